modulo_count_scheduler: RTL and testbench

MODULO_COUNT_SCHEDULER -- requirements
Module: modulo_count_scheduler

---
 rtl/modulo_count_scheduler_if.sv | 29 ++
 rtl/modulo_count_scheduler.sv | 178 +++++++++++++++++
 tb/tb_modulo_count_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/modulo_count_scheduler_if.sv
// Request/limit inputs and grant/count status of the modulo count scheduler.
// The scheduler is the slave; whoever issues requests is the master.
interface modulo_count_scheduler_if #(
    parameter int WIDTH   = 4,
    parameter int WRAPS_W = 4
);
    logic [1:0]         req;
    logic [WIDTH-1:0]   limit0;
    logic [WIDTH-1:0]   limit1;
    logic [WRAPS_W-1:0] wraps0;
    logic [WRAPS_W-1:0] wraps1;
    logic               count_en;
    logic [1:0]         grant;
    logic               busy;
    logic [WIDTH-1:0]   count;
    logic               done;
    logic               abort;
    logic               owner_id;

    modport master (
        output req, limit0, limit1, wraps0, wraps1, count_en,
        input  grant, busy, count, done, abort, owner_id
    );

    modport slave (
        input  req, limit0, limit1, wraps0, wraps1, count_en,
        output grant, busy, count, done, abort, owner_id
    );
endinterface

// File: rtl/modulo_count_scheduler.sv
// Two-requester round-robin owner of a shared modulo counter: the winner's
// limit and wrap target are latched at grant, and the run ends in done or abort.
module modulo_count_scheduler #(
    parameter int WIDTH   = 4,
    parameter int WRAPS_W = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    modulo_count_scheduler_if.slave sched
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]   COUNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   COUNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAPS_W-1:0] WRAP_ZERO  = {WRAPS_W{1'b0}};
    localparam logic [WRAPS_W-1:0] WRAP_ONE   = {{(WRAPS_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [1:0]         grant_r, grant_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               abort_r, abort_s;
    logic               owner_r, owner_s;
    logic               last_r, last_s;
    logic [WIDTH-1:0]   count_r, count_s;
    logic [WIDTH-1:0]   limit_q_r, limit_q_s;
    logic [WRAPS_W-1:0] target_q_r, target_q_s;
    logic [WRAPS_W-1:0] wrap_cnt_r, wrap_cnt_s;
    logic [WRAPS_W-1:0] wrap_inc_s;
    logic               win_s;
    logic               owner_lost_s;

    // A requested wrap count of zero still means one full pass.
    function automatic logic [WRAPS_W-1:0] wrap_target(input logic [WRAPS_W-1:0] wraps);
        logic [WRAPS_W-1:0] tgt;
        if (wraps == WRAP_ZERO) begin
            tgt = WRAP_ONE;
        end else begin
            tgt = wraps;
        end
        return tgt;
    endfunction

    // On contention the requester not served last wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last);
        logic win;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
        return win;
    endfunction

    // Next-state and next-output decode; losing the owner's request beats completion.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        busy_s       = busy_r;
        count_s      = count_r;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        owner_s      = owner_r;
        last_s       = last_r;
        limit_q_s    = limit_q_r;
        target_q_s   = target_q_r;
        wrap_cnt_s   = wrap_cnt_r;
        win_s        = pick_winner(sched.req, last_r);
        wrap_inc_s   = wrap_cnt_r + WRAP_ONE;
        owner_lost_s = ((state_r == LOAD) || (state_r == RUN)) && !sched.req[owner_r];

        if (owner_lost_s) begin
            state_s = IDLE;
            abort_s = 1'b1;
            grant_s = 2'b00;
            busy_s  = 1'b0;
            count_s = COUNT_ZERO;
            last_s  = owner_r;
        end else begin
            case (state_r)
                IDLE: begin
                    grant_s = 2'b00;
                    busy_s  = 1'b0;
                    count_s = COUNT_ZERO;
                    if (sched.req != 2'b00) begin
                        state_s    = LOAD;
                        grant_s    = win_s ? 2'b10 : 2'b01;
                        busy_s     = 1'b1;
                        owner_s    = win_s;
                        limit_q_s  = win_s ? sched.limit1 : sched.limit0;
                        target_q_s = wrap_target(win_s ? sched.wraps1 : sched.wraps0);
                        wrap_cnt_s = WRAP_ZERO;
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD: begin
                    state_s = RUN;
                end
                RUN: begin
                    if (sched.count_en) begin
                        if (count_r == limit_q_r) begin
                            count_s    = COUNT_ZERO;
                            wrap_cnt_s = wrap_inc_s;
                            if (wrap_inc_s == target_q_r) begin
                                state_s = DONE;
                                done_s  = 1'b1;
                                grant_s = 2'b00;
                            end else begin
                                state_s = RUN;
                            end
                        end else begin
                            count_s = count_r + COUNT_ONE;
                        end
                    end else begin
                        state_s = RUN;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                    grant_s = 2'b00;
                    busy_s  = 1'b0;
                    count_s = COUNT_ZERO;
                    last_s  = owner_r;
                end
                default: begin
                    state_s = IDLE;
                    grant_s = 2'b00;
                    busy_s  = 1'b0;
                    count_s = COUNT_ZERO;
                end
            endcase
        end
    end

    // State and registered outputs; reset favours requester 0 next.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            grant_r    <= 2'b00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            abort_r    <= 1'b0;
            owner_r    <= 1'b0;
            last_r     <= 1'b1;
            count_r    <= COUNT_ZERO;
            limit_q_r  <= COUNT_ZERO;
            target_q_r <= WRAP_ONE;
            wrap_cnt_r <= WRAP_ZERO;
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            abort_r    <= abort_s;
            owner_r    <= owner_s;
            last_r     <= last_s;
            count_r    <= count_s;
            limit_q_r  <= limit_q_s;
            target_q_r <= target_q_s;
            wrap_cnt_r <= wrap_cnt_s;
        end
    end

    assign sched.grant    = grant_r;
    assign sched.busy     = busy_r;
    assign sched.count    = count_r;
    assign sched.done     = done_r;
    assign sched.abort    = abort_r;
    assign sched.owner_id = owner_r;

endmodule

// File: tb/tb_modulo_count_scheduler.sv
// Directed scenarios plus randomized traffic against a run-length model of the scheduler.
module tb_modulo_count_scheduler;
    localparam int WIDTH   = 4;
    localparam int WRAPS_W = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    modulo_count_scheduler_if #(.WIDTH(WIDTH), .WRAPS_W(WRAPS_W)) sif ();

    modulo_count_scheduler #(.WIDTH(WIDTH), .WRAPS_W(WRAPS_W)) dut (
        .clock (clock),
        .reset (reset),
        .sched (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a run is (limit+1)*max(wraps,1) enabled cycles; count is elapsed mod (limit+1).
    int m_phase;   // 0 idle, 1 load, 2 run, 3 done
    int m_owner;
    int m_last;
    int m_lim;
    int m_total;
    int m_elapsed;
    int m_done;
    int m_abort;

    int exp035 [10] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int exp037 [4]  = '{1, 1, 2, 2};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int tgt;
        m_done  = 0;
        m_abort = 0;
        if (reset) begin
            m_phase   = 0;
            m_owner   = 0;
            m_last    = 1;
            m_elapsed = 0;
        end else if ((m_phase == 1 || m_phase == 2) && !sif.req[m_owner]) begin
            m_phase = 0;
            m_abort = 1;
            m_last  = m_owner;
        end else if (m_phase == 0) begin
            if (sif.req != 2'b00) begin
                if (sif.req == 2'b11) m_owner = 1 - m_last;
                else                  m_owner = (sif.req == 2'b10) ? 1 : 0;
                m_lim     = m_owner ? int'(sif.limit1) : int'(sif.limit0);
                tgt       = m_owner ? int'(sif.wraps1) : int'(sif.wraps0);
                if (tgt == 0) tgt = 1;
                m_total   = (m_lim + 1) * tgt;
                m_elapsed = 0;
                m_phase   = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (sif.count_en) begin
                m_elapsed++;
                if (m_elapsed == m_total) begin
                    m_phase = 3;
                    m_done  = 1;
                end
            end
        end else begin
            m_phase = 0;
            m_last  = m_owner;
        end
    endtask

    // One clock: update the model on the edge, compare everything half a cycle later.
    task automatic tick();
        int eg;
        int ec;
        @(posedge clock);
        model_step();
        @(negedge clock);
        eg = (m_phase == 1 || m_phase == 2) ? (m_owner ? 2 : 1) : 0;
        ec = (m_phase == 2) ? (m_elapsed % (m_lim + 1)) : 0;
        check_val("grant",    32'(sif.grant),    32'(eg));
        check_val("busy",     32'(sif.busy),     32'(m_phase != 0));
        check_val("count",    32'(sif.count),    32'(ec));
        check_val("done",     32'(sif.done),     32'(m_done));
        check_val("abort",    32'(sif.abort),    32'(m_abort));
        check_val("owner_id", 32'(sif.owner_id), 32'(m_owner));
    endtask

    initial begin
        reset        = 1'b1;
        sif.req      = 2'b00;
        sif.limit0   = 4'd0;
        sif.limit1   = 4'd0;
        sif.wraps0   = 4'd0;
        sif.wraps1   = 4'd0;
        sif.count_en = 1'b0;
        m_phase = 0; m_owner = 0; m_last = 1; m_lim = 0; m_total = 1; m_elapsed = 0;
        m_done = 0; m_abort = 0;
        tick();
        tick();
        check_val("rst_grant", 32'(sif.grant), 32'd0);
        check_val("rst_busy",  32'(sif.busy),  32'd0);
        check_val("rst_count", 32'(sif.count), 32'd0);
        reset = 1'b0;
        tick();

        // Two wraps of 0..3 on requester 0
        sif.req = 2'b01; sif.limit0 = 4'd3; sif.wraps0 = 4'd2; sif.count_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("seq_count", 32'(sif.count), 32'(exp035[i]));
            check_val("seq_done",  32'(sif.done),  32'(i == 9));
            if (i == 0) check_val("seq_grant", 32'(sif.grant), 32'd1);
        end
        check_val("seq_owner", 32'(sif.owner_id), 32'd0);
        sif.req = 2'b00;
        tick();

        // Zero limit and zero wraps: a single enabled cycle
        sif.req = 2'b10; sif.limit1 = 4'd0; sif.wraps1 = 4'd0;
        tick();
        tick();
        tick();
        check_val("z_done",  32'(sif.done),     32'd1);
        check_val("z_owner", 32'(sif.owner_id), 32'd1);
        sif.req = 2'b00;
        tick();

        // Round-robin alternation under continuous contention from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sif.req = 2'b11; sif.limit0 = 4'd1; sif.limit1 = 4'd1; sif.wraps0 = 4'd1; sif.wraps1 = 4'd1;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 5; j++) begin
                tick();
                if (j == 0) begin
                    check_val("rr_owner", 32'(sif.owner_id), 32'(k % 2));
                    check_val("rr_grant", 32'(sif.grant),    32'((k % 2) ? 2 : 1));
                end
            end
        end
        sif.req = 2'b00;
        tick();

        // Count enable gating
        sif.req = 2'b01; sif.limit0 = 4'd5; sif.wraps0 = 4'd1; sif.count_en = 1'b1;
        tick();
        tick();
        for (int p = 0; p < 4; p++) begin
            sif.count_en = (p % 2 == 0);
            tick();
            check_val("en_count", 32'(sif.count), 32'(exp037[p]));
        end
        sif.count_en = 1'b1;
        sif.req = 2'b00;
        tick();
        tick();

        // Owner drops its request mid-run
        sif.req = 2'b01; sif.limit0 = 4'd7; sif.wraps0 = 4'd1;
        for (int i = 0; i < 6; i++) tick();
        check_val("ab_pre_count", 32'(sif.count), 32'd4);
        sif.req = 2'b00;
        tick();
        check_val("ab_abort", 32'(sif.abort), 32'd1);
        check_val("ab_done",  32'(sif.done),  32'd0);
        check_val("ab_grant", 32'(sif.grant), 32'd0);
        check_val("ab_count", 32'(sif.count), 32'd0);
        tick();

        // Reset in the middle of a run, then a fresh grant
        sif.req = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        check_val("mr_pre_count", 32'(sif.count), 32'd2);
        reset = 1'b1;
        tick();
        check_val("mr_busy",  32'(sif.busy),  32'd0);
        check_val("mr_done",  32'(sif.done),  32'd0);
        check_val("mr_count", 32'(sif.count), 32'd0);
        reset = 1'b0;
        sif.req = 2'b10; sif.limit1 = 4'd2;
        tick();
        check_val("mr_grant", 32'(sif.grant), 32'd2);
        sif.req = 2'b00;
        tick();

        // Randomized traffic: sticky requests, churning limits, sparse resets
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 24) == 0) sif.req[0] = ~sif.req[0];
            if ($urandom_range(0, 24) == 0) sif.req[1] = ~sif.req[1];
            sif.count_en = ($urandom_range(0, 3) != 0);
            sif.limit0   = WIDTH'($urandom_range(0, 5));
            sif.limit1   = WIDTH'($urandom_range(0, 5));
            sif.wraps0   = WRAPS_W'($urandom_range(0, 3));
            sif.wraps1   = WRAPS_W'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
